// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared RV32I definitions for the decode and execute stages: major
//   opcode constants, legal funct7 values for register-register ops,
//   the one-hot ALU class vector and the decoded pipeline entry.
//   No ports (package).

package riscv_pkg;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // One bit per ALU class; at most one bit set, none when illegal.
    typedef struct packed {
        logic branch;
        logic jalr;
        logic jal;
        logic lui;
        logic auipc;
        logic op_imm;
        logic op;
    } alu_class_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        alu_class_t  alu_class;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] immediate;
        logic        illegal;
    } decoded_entry_t;

endpackage

// File: rtl/decode_if.sv
// fetch_if / decode_if
//   fetch_if  : fetch -> decode handshake
//     fetch_valid, fetch_instruction, fetch_pc (master out), fetch_ready (master in)
//   decode_if : decode -> execute handshake
//     decode_valid, instruction, pc, alu_*_enable, rs1, rs2, rd, funct3,
//     immediate, illegal (master out), execute_ready (master in)

interface fetch_if;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instruction;
    logic [31:0] fetch_pc;

    modport master (
        output fetch_valid, fetch_instruction, fetch_pc,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid, fetch_instruction, fetch_pc,
        output fetch_ready
    );
endinterface

interface decode_if;
    logic        decode_valid;
    logic        execute_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        alu_branch_enable;
    logic        alu_unconditional_jalr_enable;
    logic        alu_unconditional_jal_enable;
    logic        alu_upper_immediate_lui_enable;
    logic        alu_upper_immediate_auipc_enable;
    logic        alu_register_immediate_enable;
    logic        alu_register_register_enable;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] immediate;
    logic        illegal;

    modport master (
        output decode_valid, instruction, pc,
               alu_branch_enable, alu_unconditional_jalr_enable,
               alu_unconditional_jal_enable, alu_upper_immediate_lui_enable,
               alu_upper_immediate_auipc_enable, alu_register_immediate_enable,
               alu_register_register_enable,
               rs1, rs2, rd, funct3, immediate, illegal,
        input  execute_ready
    );

    modport slave (
        input  decode_valid, instruction, pc,
               alu_branch_enable, alu_unconditional_jalr_enable,
               alu_unconditional_jal_enable, alu_upper_immediate_lui_enable,
               alu_upper_immediate_auipc_enable, alu_register_immediate_enable,
               alu_register_register_enable,
               rs1, rs2, rd, funct3, immediate, illegal,
        output execute_ready
    );
endinterface

// File: rtl/decode_imm_gen.sv
// decode_imm_gen
//   Combinational RV32I classifier: opcode -> one-hot ALU class,
//   sign-extended immediate, register fields and illegal flag.
//   Ports:
//     instruction  in  32  raw instruction word
//     pc           in  32  address of the word (carried into the entry)
//     entry        out     decoded_entry_t for the pipeline register

module decode_imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0]    instruction,
    input  logic [31:0]    pc,
    output decoded_entry_t entry
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm_b;
    logic [31:0] imm_j;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    // Every supported opcode ends in 2'b11, so matching the full 7-bit
    // opcode also rejects compressed-style encodings.
    always_comb begin
        entry             = '0;
        entry.instruction = instruction;
        entry.pc          = pc;
        entry.rs1         = instruction[19:15];
        entry.rs2         = instruction[24:20];
        entry.rd          = instruction[11:7];
        entry.funct3      = funct3;
        entry.illegal     = 1'b1;
        case (opcode)
            OPCODE_BRANCH: begin
                entry.alu_class.branch = 1'b1;
                entry.immediate        = imm_b;
                entry.illegal          = 1'b0;
            end
            OPCODE_JALR: begin
                if (funct3 == 3'b000) begin
                    entry.alu_class.jalr = 1'b1;
                    entry.immediate      = imm_i;
                    entry.illegal        = 1'b0;
                end
            end
            OPCODE_JAL: begin
                entry.alu_class.jal = 1'b1;
                entry.immediate     = imm_j;
                entry.illegal       = 1'b0;
            end
            OPCODE_LUI: begin
                entry.alu_class.lui = 1'b1;
                entry.immediate     = imm_u;
                entry.illegal       = 1'b0;
            end
            OPCODE_AUIPC: begin
                entry.alu_class.auipc = 1'b1;
                entry.immediate       = imm_u;
                entry.illegal         = 1'b0;
            end
            OPCODE_OP_IMM: begin
                entry.alu_class.op_imm = 1'b1;
                entry.immediate        = imm_i;
                entry.illegal          = 1'b0;
            end
            OPCODE_OP: begin
                if ((funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT)) begin
                    entry.alu_class.op = 1'b1;
                    entry.illegal      = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode.sv
// decode
//   RV32I decode stage: classifies fetched words and holds the decoded
//   entry in a registered pipeline slot until execute consumes it.
//   Build option: DECODE_SKID_EN adds a second (skid) entry so that
//   fetch_ready is a flop rather than a path from execute_ready.
//   Ports:
//     clock    in   rising-edge clock
//     reset_n  in   asynchronous active-low reset
//     flush    in   redirect; next edge discards all held entries and the
//                   word offered this cycle
//     fetch    fetch_if.slave   instruction input handshake
//     issue    decode_if.master decoded entry to execute

module decode
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic     clock,
    input  logic     reset_n,
    input  logic     flush,
    fetch_if.slave   fetch,
    decode_if.master issue
);

    decoded_entry_t  in_entry;
    decoded_entry_t  main_q;
    logic            main_valid_q;
    logic            take_in;
    logic [XLEN-1:0] pc_out;

    decode_imm_gen u_imm_gen (
        .instruction (fetch.fetch_instruction),
        .pc          (fetch.fetch_pc),
        .entry       (in_entry)
    );

`ifdef DECODE_SKID_EN
    decoded_entry_t skid_q;
    logic           skid_valid_q;
    logic           main_free;

    assign fetch.fetch_ready = !skid_valid_q;
    assign take_in           = fetch.fetch_valid && !skid_valid_q;
    assign main_free         = !main_valid_q || issue.execute_ready;

    // A word is accepted whenever the skid slot is empty. If main is also
    // draining it goes straight to main; otherwise it parks in skid.
    // Skid always refills main first, which keeps arrival order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_q       <= skid_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (take_in) begin
                main_q       <= in_entry;
                main_valid_q <= 1'b1;
            end else begin
                main_valid_q <= 1'b0;
            end
        end else if (take_in) begin
            skid_q       <= in_entry;
            skid_valid_q <= 1'b1;
        end
    end
`else
    assign fetch.fetch_ready = !main_valid_q || issue.execute_ready;
    assign take_in           = fetch.fetch_valid && fetch.fetch_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
        end else if (flush) begin
            main_valid_q <= 1'b0;
        end else if (take_in) begin
            main_q       <= in_entry;
            main_valid_q <= 1'b1;
        end else if (issue.execute_ready) begin
            main_valid_q <= 1'b0;
        end
    end
`endif

    assign pc_out = main_q.pc[XLEN-1:0];

    assign issue.decode_valid                     = main_valid_q;
    assign issue.instruction                      = main_q.instruction;
    assign issue.pc                               = pc_out;
    assign issue.alu_branch_enable                = main_q.alu_class.branch;
    assign issue.alu_unconditional_jalr_enable    = main_q.alu_class.jalr;
    assign issue.alu_unconditional_jal_enable     = main_q.alu_class.jal;
    assign issue.alu_upper_immediate_lui_enable   = main_q.alu_class.lui;
    assign issue.alu_upper_immediate_auipc_enable = main_q.alu_class.auipc;
    assign issue.alu_register_immediate_enable    = main_q.alu_class.op_imm;
    assign issue.alu_register_register_enable     = main_q.alu_class.op;
    assign issue.rs1                              = main_q.rs1;
    assign issue.rs2                              = main_q.rs2;
    assign issue.rd                               = main_q.rd;
    assign issue.funct3                           = main_q.funct3;
    assign issue.immediate                        = main_q.immediate;
    assign issue.illegal                          = main_q.illegal;

endmodule

// File: tb/tb_decode.sv
// tb_decode
//   Directed bench for decode: reset state, per-class decode, back-to-back
//   throughput, stall with ordering, flush, illegal encodings and reset
//   while an entry is held.

module tb_decode;

    logic clock = 1'b0;
    logic reset_n;
    logic flush;

    fetch_if  fif ();
    decode_if dif ();

    decode #(.XLEN(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .fetch   (fif),
        .issue   (dif)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    // Class vector order: branch, jalr, jal, lui, auipc, op_imm, op
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_BR    = 7'b1000000;
    localparam logic [6:0] C_JALR  = 7'b0100000;
    localparam logic [6:0] C_JAL   = 7'b0010000;
    localparam logic [6:0] C_LUI   = 7'b0001000;
    localparam logic [6:0] C_AUIPC = 7'b0000100;
    localparam logic [6:0] C_RI    = 7'b0000010;
    localparam logic [6:0] C_RR    = 7'b0000001;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] cls_now();
        return {25'd0,
                dif.alu_branch_enable, dif.alu_unconditional_jalr_enable,
                dif.alu_unconditional_jal_enable, dif.alu_upper_immediate_lui_enable,
                dif.alu_upper_immediate_auipc_enable, dif.alu_register_immediate_enable,
                dif.alu_register_register_enable};
    endfunction

    task automatic check_entry(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                               input logic [6:0] cls, input logic [31:0] imm, input logic ill);
        check({tag, "_valid"},  {31'd0, dif.decode_valid}, 32'd1);
        check({tag, "_instr"},  dif.instruction, ins);
        check({tag, "_pc"},     dif.pc, pc);
        check({tag, "_class"},  cls_now(), {25'd0, cls});
        check({tag, "_imm"},    dif.immediate, imm);
        check({tag, "_illegal"}, {31'd0, dif.illegal}, {31'd0, ill});
        check({tag, "_regs"},   {17'd0, dif.rs1, dif.rs2, dif.rd},
                                {17'd0, ins[19:15], ins[24:20], ins[11:7]});
        check({tag, "_funct3"}, {29'd0, dif.funct3}, {29'd0, ins[14:12]});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'd0, dif.decode_valid}, 32'd0);
        check({tag, "_instr"}, dif.instruction, 32'd0);
        check({tag, "_pc"},    dif.pc, 32'd0);
        check({tag, "_imm"},   dif.immediate, 32'd0);
        check({tag, "_class"}, cls_now(), 32'd0);
        check({tag, "_misc"},  {13'd0, dif.rs1, dif.rs2, dif.rd, dif.funct3, dif.illegal}, 32'd0);
    endtask

    localparam int NV = 11;
    logic [31:0] v_ins [NV];
    logic [6:0]  v_cls [NV];
    logic [31:0] v_imm [NV];
    logic        v_ill [NV];

    logic [31:0] s_ins [4];
    logic [31:0] s_imm [4];

    initial begin
        // Hand-decoded vectors
        v_ins[0]  = 32'hFFF00093; v_cls[0]  = C_RI;    v_imm[0]  = 32'hFFFFFFFF; v_ill[0]  = 1'b0; // addi x1,x0,-1
        v_ins[1]  = 32'hFFDFF0EF; v_cls[1]  = C_JAL;   v_imm[1]  = 32'hFFFFFFFC; v_ill[1]  = 1'b0; // jal x1,-4
        v_ins[2]  = 32'h123452B7; v_cls[2]  = C_LUI;   v_imm[2]  = 32'h12345000; v_ill[2]  = 1'b0; // lui x5,0x12345
        v_ins[3]  = 32'hFE000EE3; v_cls[3]  = C_BR;    v_imm[3]  = 32'hFFFFFFFC; v_ill[3]  = 1'b0; // beq x0,x0,-4
        v_ins[4]  = 32'h008100E7; v_cls[4]  = C_JALR;  v_imm[4]  = 32'h00000008; v_ill[4]  = 1'b0; // jalr x1,8(x2)
        v_ins[5]  = 32'hFFFFF197; v_cls[5]  = C_AUIPC; v_imm[5]  = 32'hFFFFF000; v_ill[5]  = 1'b0; // auipc x3,0xFFFFF
        v_ins[6]  = 32'h40001033; v_cls[6]  = C_RR;    v_imm[6]  = 32'h00000000; v_ill[6]  = 1'b0; // funct7 0100000
        v_ins[7]  = 32'h00002003; v_cls[7]  = C_NONE;  v_imm[7]  = 32'h00000000; v_ill[7]  = 1'b1; // load
        v_ins[8]  = 32'h42001033; v_cls[8]  = C_NONE;  v_imm[8]  = 32'h00000000; v_ill[8]  = 1'b1; // funct7 0100001
        v_ins[9]  = 32'h008110E7; v_cls[9]  = C_NONE;  v_imm[9]  = 32'h00000000; v_ill[9]  = 1'b1; // jalr funct3 001
        v_ins[10] = 32'h00000010; v_cls[10] = C_NONE;  v_imm[10] = 32'h00000000; v_ill[10] = 1'b1; // low bits 00

        s_ins[0] = 32'h00100093; s_imm[0] = 32'd1; // addi x1,x0,1
        s_ins[1] = 32'h00200113; s_imm[1] = 32'd2; // addi x2,x0,2
        s_ins[2] = 32'h00300193; s_imm[2] = 32'd3; // addi x3,x0,3
        s_ins[3] = 32'h00400213; s_imm[3] = 32'd4; // addi x4,x0,4

        reset_n               = 1'b0;
        flush                 = 1'b0;
        fif.fetch_valid       = 1'b0;
        fif.fetch_instruction = 32'd0;
        fif.fetch_pc          = 32'd0;
        dif.execute_ready     = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        step();
        check("reset_fetch_ready", {31'd0, fif.fetch_ready}, 32'd1);
        check("reset_valid_idle", {31'd0, dif.decode_valid}, 32'd0);

        // Back-to-back decode of every class plus illegal encodings
        dif.execute_ready = 1'b1;
        for (int k = 0; k < NV; k++) begin
            fif.fetch_valid       = 1'b1;
            fif.fetch_instruction = v_ins[k];
            fif.fetch_pc          = 32'h1000 + 32'(k * 4);
            #1;
            check($sformatf("vec%0d_fetch_ready", k), {31'd0, fif.fetch_ready}, 32'd1);
            @(posedge clock);
            #1;
            fif.fetch_valid = 1'b0;
            check_entry($sformatf("vec%0d", k), v_ins[k], 32'h1000 + 32'(k * 4),
                        v_cls[k], v_imm[k], v_ill[k]);
        end
        step();
        check("vec_drained", {31'd0, dif.decode_valid}, 32'd0);

        // Stream of four words with execute_ready low for two cycles
        begin
            int idx;
            int delivered;
            idx       = 0;
            delivered = 0;
            for (int cyc = 0; cyc < 10; cyc++) begin
                dif.execute_ready = !(cyc == 2 || cyc == 3);
                fif.fetch_valid   = (idx < 4);
                if (idx < 4) begin
                    fif.fetch_instruction = s_ins[idx];
                    fif.fetch_pc          = 32'h300 + 32'(idx * 4);
                end
                #1;
`ifdef DECODE_SKID_EN
                if (cyc == 2) check("stream_ready_one_held", {31'd0, fif.fetch_ready}, 32'd1);
                if (cyc == 3) check("stream_ready_two_held", {31'd0, fif.fetch_ready}, 32'd0);
`else
                if (cyc == 2) check("stream_ready_stall_a", {31'd0, fif.fetch_ready}, 32'd0);
                if (cyc == 3) check("stream_ready_stall_b", {31'd0, fif.fetch_ready}, 32'd0);
`endif
                if (dif.decode_valid) begin
                    if (delivered < 4) begin
                        check_entry($sformatf("stream%0d", delivered), s_ins[delivered],
                                    32'h300 + 32'(delivered * 4), C_RI, s_imm[delivered], 1'b0);
                        if (dif.execute_ready) delivered++;
                    end else begin
                        check("stream_extra_valid", {31'd0, dif.decode_valid}, 32'd0);
                    end
                end
                if (fif.fetch_valid && fif.fetch_ready) idx++;
                @(posedge clock);
                #1;
            end
            fif.fetch_valid = 1'b0;
            check("stream_accepted", 32'(idx), 32'd4);
            check("stream_delivered", 32'(delivered), 32'd4);
        end

        // Flush with an entry held and a word offered in the same cycle
        fif.fetch_valid       = 1'b1;
        fif.fetch_instruction = 32'h00500293;
        fif.fetch_pc          = 32'h400;
        dif.execute_ready     = 1'b0;
        step();
        check_entry("flush_pre", 32'h00500293, 32'h400, C_RI, 32'd5, 1'b0);
        flush                 = 1'b1;
        fif.fetch_instruction = 32'h00600313;
        fif.fetch_pc          = 32'h404;
        dif.execute_ready     = 1'b1;
        #1;
        check("flush_offer_ready", {31'd0, fif.fetch_ready}, 32'd1);
        step();
        flush           = 1'b0;
        fif.fetch_valid = 1'b0;
        check("flush_valid_cleared", {31'd0, dif.decode_valid}, 32'd0);
        step();
        check("flush_word_dropped", {31'd0, dif.decode_valid}, 32'd0);
        fif.fetch_valid       = 1'b1;
        fif.fetch_instruction = 32'h00700393;
        fif.fetch_pc          = 32'h408;
        step();
        fif.fetch_valid = 1'b0;
        check_entry("post_flush", 32'h00700393, 32'h408, C_RI, 32'd7, 1'b0);
        step();
        check("post_flush_drained", {31'd0, dif.decode_valid}, 32'd0);

        // Asynchronous reset while an entry is held
        fif.fetch_valid       = 1'b1;
        fif.fetch_instruction = 32'hFFF00093;
        fif.fetch_pc          = 32'h500;
        dif.execute_ready     = 1'b0;
        step();
        fif.fetch_valid = 1'b0;
        check("midrst_pre_valid", {31'd0, dif.decode_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("midrst");
        step();
        reset_n = 1'b1;
        step();
        check("midrst_fetch_ready", {31'd0, fif.fetch_ready}, 32'd1);
        check("midrst_valid_idle", {31'd0, dif.decode_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decode.md
# decode

Decode stage of the RV32I-minimum pipeline, directly upstream of `execute`. Accepts fetched instruction words with a valid/ready handshake, classifies the opcode into the one-hot ALU class enables `execute` consumes, extracts register indices and the sign-extended immediate, and holds the result in a pipeline register until `execute` takes it. Supports flush on redirect and flags unsupported encodings.

## Interface

Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fetch_valid`  in  1  fetch presents a word.
- `fetch_ready`  out  1  decode accepts the word this cycle.
- `fetch_instruction`  in  32  instruction word.
- `fetch_pc`  in  32  address of the word.
- `flush`  in  1  redirect from `execute` (`next_pc_valid`); discards all held entries.
- `decode_valid`  out  1  decoded entry presented to `execute`.
- `execute_ready`  in  1  `execute` consumes the entry this cycle.
- `instruction`  out  32  held instruction word.
- `pc`  out  32  held PC.
- `alu_branch_enable`, `alu_unconditional_jalr_enable`, `alu_unconditional_jal_enable`, `alu_upper_immediate_lui_enable`, `alu_upper_immediate_auipc_enable`, `alu_register_immediate_enable`, `alu_register_register_enable`  out  1 each  one-hot class; all 0 when illegal.
- `rs1`, `rs2`, `rd`  out  5 each  instr[19:15], [24:20], [11:7].
- `funct3`  out  3  instr[14:12].
- `immediate`  out  32  sign-extended immediate for the class (0 for R-type).
- `illegal`  out  1  unsupported encoding.

## Operation

- Transfer in: `fetch_valid && fetch_ready`; transfer out: `decode_valid && execute_ready`.
- Class by opcode instr[6:0]: 1100011 branch (B-imm), 1100111 jalr (I-imm, funct3 must be 000), 1101111 jal (J-imm), 0110111 lui (U-imm), 0010111 auipc (U-imm), 0010011 reg-imm (I-imm), 0110011 reg-reg (funct7 must be 0000000 or 0100000).
- Anything else, instr[1:0]≠11, or failed funct check: `illegal`=1, all enables 0, immediate 0; the entry still flows to `execute` in order.
- Immediates: I={{20{i[31]}},i[31:20]}; U={i[31:12],12'b0}; B={{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}; J={{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}.
- Decode is computed on the incoming word and registered; outputs are registers, never combinational from `fetch_*`.
- `flush` (sync): next edge clears all valid bits; a word offered in the same cycle is dropped even if `fetch_ready`=1. `flush` overrides a simultaneous out-transfer (entry treated as consumed/dropped).
- Entries leave in arrival order; no entry duplicated or lost absent flush.

## Timing

- Reset (async assert, sync deassert by system): `decode_valid`=0, all data/enable/`illegal` outputs 0, skid slot empty; `fetch_ready`=1 in the first cycle after reset.
- Latency: word accepted at edge N is presented with `decode_valid`=1 after edge N.
- Throughput: one instruction per cycle while `execute_ready`=1.
- Output fields stay stable while `decode_valid && !execute_ready`.

## Configuration

- `DECODE_SKID_EN` defined: 2-entry skid (main + skid register); `fetch_ready` is a register = skid empty; on stall an accepted word parks in skid, moved to main when main drains. Full throughput with no combinational ready path.
- Undefined: single register; `fetch_ready = !decode_valid || execute_ready` (combinational from `execute_ready`).
- Visible behaviour (order, latency, flush) identical in both builds except the ready path.

## Structure

- Shared package `riscv_pkg`: opcode constants (`OPCODE_BRANCH`, `OPCODE_JALR`, `OPCODE_JAL`, `OPCODE_LUI`, `OPCODE_AUIPC`, `OPCODE_OP_IMM`, `OPCODE_OP`), funct7 legal values, decoded-entry struct type used by this block and `execute`.
- Sub-module `decode_imm_gen`: combinational instruction → class one-hot, immediate, illegal; instantiated once on the input side (skid stores decoded entries).

## Test plan

- Reset mid-stream with `decode_valid`=1 → outputs all 0 immediately, `fetch_ready`=1 after release.
- `addi x1,x0,-1` (0xFFF00093), `execute_ready`=1 → next cycle `alu_register_immediate_enable`=1, rd=1, immediate=0xFFFFFFFF.
- `jal x1,-4` (0xFFDFF0EF) then `lui x5,0x12345` (0x123452B7) back-to-back → J-imm 0xFFFFFFFC, then U-imm 0x12345000, one per cycle.
- Stream 4 words, hold `execute_ready`=0 two cycles → no loss/duplication, fields stable; with `DECODE_SKID_EN` `fetch_ready` drops only after 2 held.
- `flush`=1 with `fetch_valid`=1 and entry held → next cycle `decode_valid`=0, offered word never appears.
- 0x00002003 (load) and 0x40001033 with funct7=0100001 variant → `illegal`=1, all enables 0, entry delivered.
